// File: rtl/axi_line_fetch.sv
// AXI4 read-burst line fetcher: one INCR/WRAP burst per request, R beats assembled
// into a line, completed lines queued in a first-word-fall-through FIFO.
module axi_line_fetch #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 64,
    parameter int         LINE_BEATS = 2,
    parameter int         FIFO_DEPTH = 2,
    parameter int         WRAP_MODE  = 0,
    parameter logic [3:0] AR_CACHE   = 4'b0010
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic                         flush,
    output logic                         line_valid,
    input  logic                         line_ready,
    output logic [LINE_BEATS*DATA_W-1:0] line_data,
    output logic [ADDR_W-1:0]            line_addr,
    output logic                         line_err,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [ADDR_W-1:0]            araddr,
    output logic [1:0]                   arburst,
    output logic [2:0]                   arsize,
    output logic [7:0]                   arlen,
    output logic [3:0]                   arcache,
    input  logic                         rvalid,
    output logic                         rready,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    output logic                         busy
);
    localparam int BYTES  = DATA_W / 8;
    localparam int SIZE_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(LINE_BEATS);
    localparam int OFF_W  = SIZE_W + IDX_W;
    localparam int LINE_W = LINE_BEATS * DATA_W;
    localparam int BEAT_W = IDX_W + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_AR    = 2'd1;
    localparam logic [1:0] S_R     = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'((1 << SIZE_W) - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    logic [1:0]        state;
    logic              flush_seen;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  start_q;
    logic [BEAT_W-1:0] beat_q;
    logic              err_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_next;
    logic              err_next;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [LINE_W-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic              err_mem  [FIFO_DEPTH];

    logic accept, r_beat, room, push, pop;
    logic [IDX_W-1:0] widx;
    logic unused;

    assign unused    = rresp[0];
    assign req_ready = rst_n & (state == S_IDLE) & ~flush & (count < CNT_W'(FIFO_DEPTH));
    assign accept    = req_valid & req_ready;
    assign arvalid   = (state == S_AR);
    assign rready    = (state == S_R) | (state == S_DRAIN);
    assign arburst   = (WRAP_MODE != 0) ? 2'b10 : 2'b01;
    assign arsize    = 3'(SIZE_W);
    assign arlen     = 8'(LINE_BEATS - 1);
    assign arcache   = AR_CACHE;
    assign busy      = (state != S_IDLE) | line_valid;

    assign r_beat = (state == S_R) & rvalid;
    assign room   = beat_q < BEAT_W'(LINE_BEATS);
    assign widx   = start_q + beat_q[IDX_W-1:0];
    // A flush on the rlast beat still drops the line; the burst is already over.
    assign push   = r_beat & rlast & ~flush;
    assign pop    = line_valid & line_ready & ~flush;

    always_comb begin
        line_next = line_q;
        if (room) line_next[int'(widx) * DATA_W +: DATA_W] = rdata;
        err_next = err_q | rresp[1] | ~room |
                   (rlast & (beat_q != BEAT_W'(LINE_BEATS - 1)));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            flush_seen <= 1'b0;
            araddr     <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    state  <= S_AR;
                    araddr <= (WRAP_MODE != 0) ? (req_addr & ~BEAT_MASK)
                                               : (req_addr & ~LINE_MASK);
                end
                S_AR: begin
                    if (flush) flush_seen <= 1'b1;
                    if (arready) begin
                        state      <= (flush_seen | flush) ? S_DRAIN : S_R;
                        flush_seen <= 1'b0;
                    end
                end
                S_R: begin
                    if (rvalid & rlast) state <= S_IDLE;
                    else if (flush)     state <= S_DRAIN;
                end
                default: if (rvalid & rlast) state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the line buffer and FIFO storage carry no reset; they are initialised
    // on request accept or written before use, and the outputs are gated by line_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_q  <= req_addr & ~LINE_MASK;
            start_q <= (WRAP_MODE != 0) ? req_addr[OFF_W-1:SIZE_W] : '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
        end else if (r_beat) begin
            line_q <= line_next;
            err_q  <= err_next;
            if (room) beat_q <= beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= line_next;
            addr_mem[wr_ptr] <= base_q;
            err_mem[wr_ptr]  <= err_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign line_valid = (count != '0);
    assign line_data  = line_valid ? data_mem[rd_ptr] : '0;
    assign line_addr  = line_valid ? addr_mem[rd_ptr] : '0;
    assign line_err   = line_valid ? err_mem[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_axi_line_fetch.sv
// Directed bench for axi_line_fetch: default INCR instance checked against a
// line-queue model every cycle, plus a WRAP/4-beat instance checked by literals.
module tb_axi_line_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance (INCR, 64-bit, 2 beats, depth 2)
  logic         req_valid = 0, req_ready, flush = 0;
  logic [31:0]  req_addr = 0, line_addr, araddr;
  logic         line_valid, line_ready = 0, line_err;
  logic [127:0] line_data;
  logic         arvalid, arready = 0, rready, rvalid = 0, rlast = 0, busy;
  logic [1:0]   arburst, rresp = 0;
  logic [2:0]   arsize;
  logic [7:0]   arlen;
  logic [3:0]   arcache;
  logic [63:0]  rdata = 0;

  axi_line_fetch dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .line_valid(line_valid), .line_ready(line_ready),
    .line_data(line_data), .line_addr(line_addr), .line_err(line_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arburst(arburst),
    .arsize(arsize), .arlen(arlen), .arcache(arcache), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .busy(busy));

  // WRAP instance, 4 beats
  logic         w_req_valid = 0, w_req_ready, w_flush = 0;
  logic [31:0]  w_req_addr = 0, w_line_addr, w_araddr;
  logic         w_line_valid, w_line_ready = 0, w_line_err;
  logic [255:0] w_line_data;
  logic         w_arvalid, w_arready = 0, w_rready, w_rvalid = 0, w_rlast = 0, w_busy;
  logic [1:0]   w_arburst, w_rresp = 0;
  logic [2:0]   w_arsize;
  logic [7:0]   w_arlen;
  logic [3:0]   w_arcache;
  logic [63:0]  w_rdata = 0;

  axi_line_fetch #(.LINE_BEATS(4), .WRAP_MODE(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_addr(w_req_addr), .flush(w_flush), .line_valid(w_line_valid),
    .line_ready(w_line_ready), .line_data(w_line_data), .line_addr(w_line_addr),
    .line_err(w_line_err), .arvalid(w_arvalid), .arready(w_arready), .araddr(w_araddr),
    .arburst(w_arburst), .arsize(w_arsize), .arlen(w_arlen), .arcache(w_arcache),
    .rvalid(w_rvalid), .rready(w_rready), .rdata(w_rdata), .rresp(w_rresp),
    .rlast(w_rlast), .busy(w_busy));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: queue of completed lines, built from the beats the bench sends.
  typedef struct packed {
    logic [127:0] data;
    logic [31:0]  addr;
    logic         err;
  } line_t;

  line_t       exp_q[$];
  line_t       exp_line;
  logic        exp_push = 0;
  logic [63:0] bd[8];
  logic [1:0]  br[8];

  function automatic line_t model_line(input logic [31:0] a, input int nbeats);
    line_t l;
    l.data = '0;
    l.addr = {a[31:4], 4'h0};
    l.err  = (nbeats != 2);
    for (int n = 0; n < nbeats; n++) begin
      if (n < 2) l.data[n*64 +: 64] = bd[n];
      if (br[n][1]) l.err = 1'b1;
    end
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else if (flush) exp_q.delete();
    else begin
      if (line_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_push) exp_q.push_back(exp_line);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("head_valid", line_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("head_data", line_data, exp_q[0].data);
        check("head_addr", line_addr, exp_q[0].addr);
        check("head_err", line_err, exp_q[0].err);
      end
    end
  end

  // All tasks start and end on a negedge; inputs change only there.
  task automatic issue(input logic [31:0] a);
    int k = 0;
    req_valid = 1; req_addr = a;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic ar_hs();
    check("arvalid_before_hs", arvalid, 1);
    arready = 1;
    @(negedge clk);
    arready = 0;
    check("arvalid_after_hs", arvalid, 0);
  endtask

  task automatic send_beats(input logic [31:0] a, input int nbeats, input logic expect_push);
    for (int n = 0; n < nbeats; n++) begin
      check("rready", rready, 1);
      rvalid = 1; rdata = bd[n]; rresp = br[n]; rlast = (n == nbeats - 1);
      if (n == nbeats - 1 && expect_push) begin
        exp_line = model_line(a, nbeats);
        exp_push = 1;
      end
      @(negedge clk);
    end
    rvalid = 0; rlast = 0; rresp = 0; exp_push = 0;
  endtask

  task automatic pop_one();
    line_ready = 1;
    @(negedge clk);
    line_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin bd[i] = '0; br[i] = '0; end

    // reset state
    @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_araddr", araddr, 0);
    check("rst_line_data", line_data, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // INCR 0x1008
    bd[0] = 64'hA; bd[1] = 64'hB;
    issue(32'h1008);
    check("incr_araddr", araddr, 32'h1000);
    check("incr_arburst", arburst, 2'b01);
    check("incr_arsize", arsize, 3);
    check("incr_arlen", arlen, 1);
    check("incr_arcache", arcache, 4'b0010);
    ar_hs();
    send_beats(32'h1008, 2, 1);
    check("incr_lit_valid", line_valid, 1);
    check("incr_lit_data", line_data, {64'hB, 64'hA});
    check("incr_lit_addr", line_addr, 32'h1000);
    check("incr_lit_err", line_err, 0);
    check("incr_busy", busy, 1);
    check("incr_req_ready", req_ready, 1);
    pop_one();
    check("incr_popped", line_valid, 0);
    check("incr_idle_busy", busy, 0);

    // WRAP, 4 beats, critical word first
    w_req_valid = 1; w_req_addr = 32'h2018;
    check("wrap_req_ready", w_req_ready, 1);
    @(negedge clk);
    w_req_valid = 0;
    check("wrap_arvalid", w_arvalid, 1);
    check("wrap_araddr", w_araddr, 32'h2018);
    check("wrap_arburst", w_arburst, 2'b10);
    check("wrap_arlen", w_arlen, 3);
    w_arready = 1;
    @(negedge clk);
    w_arready = 0;
    for (int n = 0; n < 4; n++) begin
      check("wrap_rready", w_rready, 1);
      w_rvalid = 1; w_rdata = 64'hD0 + 64'(n); w_rlast = (n == 3);
      @(negedge clk);
    end
    w_rvalid = 0; w_rlast = 0;
    check("wrap_valid", w_line_valid, 1);
    check("wrap_data", w_line_data, {64'hD0, 64'hD3, 64'hD2, 64'hD1});
    check("wrap_addr", w_line_addr, 32'h2000);
    check("wrap_err", w_line_err, 0);
    w_line_ready = 1;
    @(negedge clk);
    w_line_ready = 0;
    check("wrap_popped", w_line_valid, 0);

    // FIFO full back-pressure, in-order pops
    bd[0] = 64'h11; bd[1] = 64'h12;
    issue(32'h100); ar_hs(); send_beats(32'h100, 2, 1);
    bd[0] = 64'h21; bd[1] = 64'h22;
    issue(32'h208); ar_hs(); send_beats(32'h208, 2, 1);
    req_valid = 1; req_addr = 32'h300;
    check("full_req_ready0", req_ready, 0);
    check("full_head", line_addr, 32'h100);
    @(negedge clk);
    check("full_req_ready1", req_ready, 0);
    line_ready = 1;
    check("full_req_ready2", req_ready, 0);
    @(negedge clk);
    line_ready = 0;
    check("full_head_after_pop", line_addr, 32'h200);
    check("full_req_ready3", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    check("third_arvalid", arvalid, 1);
    check("third_araddr", araddr, 32'h300);
    bd[0] = 64'h31; bd[1] = 64'h32;
    ar_hs(); send_beats(32'h300, 2, 1);
    pop_one(); pop_one();
    check("full_drained", line_valid, 0);

    // flush in R after one beat, with a queued line
    bd[0] = 64'h51; bd[1] = 64'h52;
    issue(32'h600); ar_hs(); send_beats(32'h600, 2, 1);
    issue(32'h400); ar_hs();
    rvalid = 1; rdata = 64'hC0; rlast = 0;
    @(negedge clk);
    rvalid = 0; flush = 1; line_ready = 1;
    @(negedge clk);
    flush = 0; line_ready = 0;
    check("rflush_rready", rready, 1);
    check("rflush_empty", line_valid, 0);
    check("rflush_req_ready", req_ready, 0);
    rvalid = 1; rdata = 64'hC1; rlast = 1;
    @(negedge clk);
    rvalid = 0; rlast = 0;
    check("rflush_no_push", line_valid, 0);
    check("rflush_idle", busy, 0);
    check("rflush_req_ready_back", req_ready, 1);

    // flush while AR is stalled
    issue(32'h500);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("arflush_hold", arvalid, 1);
    check("arflush_addr", araddr, 32'h500);
    @(negedge clk);
    check("arflush_hold2", arvalid, 1);
    check("arflush_req_ready", req_ready, 0);
    ar_hs();
    bd[0] = 64'hE0; bd[1] = 64'hE1;
    send_beats(32'h500, 2, 0);
    check("arflush_no_push", line_valid, 0);
    check("arflush_req_ready_back", req_ready, 1);

    // error responses
    bd[0] = 64'h61; bd[1] = 64'h62; br[0] = 2'b10;
    issue(32'h700); ar_hs(); send_beats(32'h700, 2, 1);
    check("slverr_lit", line_err, 1);
    pop_one();
    br[0] = 2'b00;
    bd[0] = 64'h71;
    issue(32'h800); ar_hs(); send_beats(32'h800, 1, 1);
    check("early_last_err", line_err, 1);
    check("early_last_word1", line_data[127:64], 0);
    check("early_last_word0", line_data[63:0], 64'h71);
    pop_one();
    bd[0] = 64'h81; bd[1] = 64'h82; bd[2] = 64'h83;
    issue(32'h900); ar_hs(); send_beats(32'h900, 3, 1);
    check("long_burst_err", line_err, 1);
    check("long_burst_data", line_data, {64'h82, 64'h81});
    pop_one();

    // reset mid-burst with a queued line
    bd[0] = 64'h91; bd[1] = 64'h92;
    issue(32'hB00); ar_hs(); send_beats(32'hB00, 2, 1);
    issue(32'hA00); ar_hs();
    rvalid = 1; rdata = 64'hF0; rlast = 0;
    @(negedge clk);
    rvalid = 0;
    rst_n = 0;
    #1;
    check("mrst_arvalid", arvalid, 0);
    check("mrst_rready", rready, 0);
    check("mrst_line_valid", line_valid, 0);
    check("mrst_line_err", line_err, 0);
    check("mrst_busy", busy, 0);
    check("mrst_araddr", araddr, 0);
    check("mrst_line_data", line_data, 0);
    check("mrst_line_addr", line_addr, 0);
    check("mrst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("mrst_req_ready_back", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
